riscv_hazard_ctrl: RTL and testbench

Hazard and forwarding controller for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB).
- Keeps its own shadow pipeline of destination-register info for the EX, MEM and WB stages.
- Generates pipeline-register stall/flush strobes and the EX-stage operand forwarding selects.
- Sits beside the decoder in ID. It consumes the decoder's reg_wr_en and src_rd outputs (src_rd == SRC_RD_DME marks a load), plus EX branch resolution and memory busy signals.

---
 rtl/riscv_hazard_ctrl.sv | 154 +++++++++++++++
 tb/tb_riscv_hazard_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/riscv_hazard_ctrl.sv
// Hazard and forwarding controller for a 5-stage RV32I pipeline.
// Tracks destination-register info for EX/MEM/WB in a shadow pipeline.
// Derives stall/flush/freeze strobes and EX operand forwarding selects.
module riscv_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_hzd_id_valid,
  input  logic [REG_AW-1:0] i_hzd_id_rs1,
  input  logic [REG_AW-1:0] i_hzd_id_rs2,
  input  logic              i_hzd_id_use_rs1,
  input  logic              i_hzd_id_use_rs2,
  input  logic [REG_AW-1:0] i_hzd_id_rd,
  input  logic              i_hzd_id_reg_wr_en,
  input  logic              i_hzd_id_is_load,
  input  logic              i_hzd_ex_redirect,
  input  logic              i_hzd_mem_busy,
  output logic              o_hzd_stall_if,
  output logic              o_hzd_stall_id,
  output logic              o_hzd_flush_id,
  output logic              o_hzd_flush_ex,
  output logic              o_hzd_freeze,
  output logic [1:0]        o_hzd_fwd_a,
  output logic [1:0]        o_hzd_fwd_b,
  output logic [CNT_W-1:0]  o_hzd_lu_cnt
);

  // EX shadow entry (carries sources for forwarding)
  logic              ex_vld_q, ex_wr_q, ex_ld_q, ex_use1_q, ex_use2_q;
  logic [REG_AW-1:0] ex_rd_q, ex_rs1_q, ex_rs2_q;
  // MEM and WB shadow entries
  logic              mem_vld_q, mem_wr_q, mem_ld_q;
  logic [REG_AW-1:0] mem_rd_q;
  logic              wb_vld_q, wb_wr_q;
  logic [REG_AW-1:0] wb_rd_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic ex_writer, mem_writer, wb_writer;
  logic lu_hit, lu_stall;

  // x0 writes are discarded by the regfile, so they never create a hazard
  assign ex_writer  = ex_vld_q  & ex_wr_q  & (ex_rd_q  != '0);
  assign mem_writer = mem_vld_q & mem_wr_q & (mem_rd_q != '0);
  assign wb_writer  = wb_vld_q  & wb_wr_q  & (wb_rd_q  != '0);

  assign lu_hit = i_hzd_id_valid & ex_writer & ex_ld_q &
                  ((i_hzd_id_use_rs1 & (i_hzd_id_rs1 == ex_rd_q)) |
                   (i_hzd_id_use_rs2 & (i_hzd_id_rs2 == ex_rd_q)));

  // Control strobes: reset forces all low, then freeze > redirect > load-use
  always_comb begin
    o_hzd_stall_if = 1'b0;
    o_hzd_stall_id = 1'b0;
    o_hzd_flush_id = 1'b0;
    o_hzd_flush_ex = 1'b0;
    o_hzd_freeze   = 1'b0;
    lu_stall       = 1'b0;
    if (i_rstn) begin
      if (i_hzd_mem_busy) begin
        o_hzd_freeze   = 1'b1;
        o_hzd_stall_if = 1'b1;
        o_hzd_stall_id = 1'b1;
      end else if (i_hzd_ex_redirect) begin
        // the ID instruction is being killed, so its load-use hazard is moot
        o_hzd_flush_id = 1'b1;
        o_hzd_flush_ex = 1'b1;
      end else if (lu_hit) begin
        o_hzd_stall_if = 1'b1;
        o_hzd_stall_id = 1'b1;
        o_hzd_flush_ex = 1'b1;
        lu_stall       = 1'b1;
      end
    end
  end

  // Forwarding selects; a load still in MEM is never a source (load-use stall covers it)
  always_comb begin
    o_hzd_fwd_a = 2'b00;
    o_hzd_fwd_b = 2'b00;
    if (ex_vld_q && ex_use1_q) begin
      if (mem_writer && !mem_ld_q && (mem_rd_q == ex_rs1_q)) o_hzd_fwd_a = 2'b01;
      else if (wb_writer && (wb_rd_q == ex_rs1_q))           o_hzd_fwd_a = 2'b10;
    end
    if (ex_vld_q && ex_use2_q) begin
      if (mem_writer && !mem_ld_q && (mem_rd_q == ex_rs2_q)) o_hzd_fwd_b = 2'b01;
      else if (wb_writer && (wb_rd_q == ex_rs2_q))           o_hzd_fwd_b = 2'b10;
    end
  end

  // Shadow pipeline advance; holds while memory is busy, EX takes a bubble on flush
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      ex_vld_q  <= 1'b0;
      ex_wr_q   <= 1'b0;
      ex_ld_q   <= 1'b0;
      ex_use1_q <= 1'b0;
      ex_use2_q <= 1'b0;
      ex_rd_q   <= '0;
      ex_rs1_q  <= '0;
      ex_rs2_q  <= '0;
      mem_vld_q <= 1'b0;
      mem_wr_q  <= 1'b0;
      mem_ld_q  <= 1'b0;
      mem_rd_q  <= '0;
      wb_vld_q  <= 1'b0;
      wb_wr_q   <= 1'b0;
      wb_rd_q   <= '0;
    end else if (!i_hzd_mem_busy) begin
      wb_vld_q  <= mem_vld_q;
      wb_wr_q   <= mem_wr_q;
      wb_rd_q   <= mem_rd_q;
      mem_vld_q <= ex_vld_q;
      mem_wr_q  <= ex_wr_q;
      mem_ld_q  <= ex_ld_q;
      mem_rd_q  <= ex_rd_q;
      if (o_hzd_flush_ex) begin
        ex_vld_q  <= 1'b0;
        ex_wr_q   <= 1'b0;
        ex_ld_q   <= 1'b0;
        ex_use1_q <= 1'b0;
        ex_use2_q <= 1'b0;
        ex_rd_q   <= '0;
        ex_rs1_q  <= '0;
        ex_rs2_q  <= '0;
      end else begin
        ex_vld_q  <= i_hzd_id_valid;
        ex_wr_q   <= i_hzd_id_reg_wr_en;
        ex_ld_q   <= i_hzd_id_is_load;
        ex_use1_q <= i_hzd_id_use_rs1;
        ex_use2_q <= i_hzd_id_use_rs2;
        ex_rd_q   <= i_hzd_id_rd;
        ex_rs1_q  <= i_hzd_id_rs1;
        ex_rs2_q  <= i_hzd_id_rs2;
      end
    end
  end

  // Saturating load-use stall counter next state
  always_comb begin
    cnt_d = cnt_q;
    if (lu_stall && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  // Load-use stall counter register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign o_hzd_lu_cnt = cnt_q;

endmodule

// File: tb/tb_riscv_hazard_ctrl.sv
// Directed bench for riscv_hazard_ctrl with an instruction-level reference model.
module tb_riscv_hazard_ctrl;
  localparam int CNT_W = 2;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       id_valid = 1'b0, use1 = 1'b0, use2 = 1'b0, wr = 1'b0, ld = 1'b0;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic       redirect = 1'b0, busy = 1'b0;
  logic       stall_if, stall_id, flush_id, flush_ex, freeze;
  logic [1:0] fwd_a, fwd_b;
  logic [CNT_W-1:0] lu_cnt;

  int n_vec = 0;
  int n_err = 0;

  riscv_hazard_ctrl #(.REG_AW(5), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_hzd_id_valid(id_valid), .i_hzd_id_rs1(rs1), .i_hzd_id_rs2(rs2),
    .i_hzd_id_use_rs1(use1), .i_hzd_id_use_rs2(use2), .i_hzd_id_rd(rd),
    .i_hzd_id_reg_wr_en(wr), .i_hzd_id_is_load(ld),
    .i_hzd_ex_redirect(redirect), .i_hzd_mem_busy(busy),
    .o_hzd_stall_if(stall_if), .o_hzd_stall_id(stall_id),
    .o_hzd_flush_id(flush_id), .o_hzd_flush_ex(flush_ex), .o_hzd_freeze(freeze),
    .o_hzd_fwd_a(fwd_a), .o_hzd_fwd_b(fwd_b), .o_hzd_lu_cnt(lu_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: one record per in-flight instruction, slot 0 = EX, 1 = MEM, 2 = WB
  typedef struct packed {
    bit v; bit [4:0] rd; bit wr; bit ld; bit [4:0] rs1; bit [4:0] rs2; bit u1; bit u2;
  } ent_t;
  ent_t pipe [3];
  int   m_cnt = 0;

  function automatic bit writes(ent_t e);
    return e.v && e.wr && (e.rd != 5'd0);
  endfunction

  // {stall_if, stall_id, flush_id, flush_ex, freeze, load_use_counted}
  function automatic bit [5:0] ctrl_exp();
    bit lu;
    if (!rstn) return 6'b0;
    if (busy) return 6'b110010;
    if (redirect) return 6'b001100;
    lu = id_valid && writes(pipe[0]) && pipe[0].ld &&
         ((use1 && rs1 == pipe[0].rd) || (use2 && rs2 == pipe[0].rd));
    return lu ? 6'b110101 : 6'b0;
  endfunction

  function automatic bit [1:0] fwd_exp(bit u, bit [4:0] src);
    if (!pipe[0].v || !u) return 2'd0;
    if (writes(pipe[1]) && !pipe[1].ld && pipe[1].rd == src) return 2'd1;
    if (writes(pipe[2]) && pipe[2].rd == src) return 2'd2;
    return 2'd0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model advance
  always @(posedge clk or negedge rstn) begin
    bit [5:0] c;
    if (!rstn) begin
      foreach (pipe[i]) pipe[i] = '0;
      m_cnt = 0;
    end else begin
      c = ctrl_exp();
      if (c[0] && m_cnt < (1 << CNT_W) - 1) m_cnt++;
      if (!busy) begin
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        if (c[2]) pipe[0] = '0;
        else pipe[0] = '{v: id_valid, rd: rd, wr: wr, ld: ld, rs1: rs1, rs2: rs2, u1: use1, u2: use2};
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    bit [5:0] c;
    c = ctrl_exp();
    chk("stall_if", stall_if, c[5]);
    chk("stall_id", stall_id, c[4]);
    chk("flush_id", flush_id, c[3]);
    chk("flush_ex", flush_ex, c[2]);
    chk("freeze",   freeze,   c[1]);
    chk("fwd_a",    fwd_a, fwd_exp(pipe[0].u1, pipe[0].rs1));
    chk("fwd_b",    fwd_b, fwd_exp(pipe[0].u2, pipe[0].rs2));
    chk("lu_cnt",   lu_cnt, m_cnt);
  end

  // One instruction slot in ID; returns just after the following falling edge
  task automatic drv(input bit v, input bit [4:0] r1, input bit [4:0] r2, input bit u1,
                     input bit u2, input bit [4:0] d, input bit w, input bit l,
                     input bit rdr, input bit bsy);
    @(posedge clk); #1;
    id_valid = v; rs1 = r1; rs2 = r2; use1 = u1; use2 = u2;
    rd = d; wr = w; ld = l; redirect = rdr; busy = bsy;
    @(negedge clk); #1;
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall_if", stall_if, 0);
    chk("rst_freeze", freeze, 0);
    chk("rst_lu_cnt", lu_cnt, 0);
    rstn = 1'b1;

    // Back-to-back ALU: add x5,x1,x2 ; sub x6,x5,x3
    drv(1, 1, 2, 1, 1, 5, 1, 0, 0, 0);
    drv(1, 5, 3, 1, 1, 6, 1, 0, 0, 0);
    nop(1);
    chk("t1_fwd_a", fwd_a, 1);
    chk("t1_fwd_b", fwd_b, 0);
    chk("t1_stall", stall_if, 0);
    nop(3);

    // Distance-2: add x5 ; add x8 ; or x7,x0,x5
    drv(1, 1, 2, 1, 1, 5, 1, 0, 0, 0);
    drv(1, 1, 2, 1, 1, 8, 1, 0, 0, 0);
    drv(1, 0, 5, 1, 1, 7, 1, 0, 0, 0);
    nop(1);
    chk("t2_fwd_b_wb", fwd_b, 2);
    chk("t2_fwd_a_x0", fwd_a, 0);
    nop(3);
    // add x5 ; add x5 ; or x7,x0,x5 : MEM wins over WB
    drv(1, 1, 2, 1, 1, 5, 1, 0, 0, 0);
    drv(1, 1, 2, 1, 1, 5, 1, 0, 0, 0);
    drv(1, 0, 5, 1, 1, 7, 1, 0, 0, 0);
    nop(1);
    chk("t2_fwd_b_mem", fwd_b, 1);
    nop(3);

    // Load-use: lw x5,0(x1) ; add x6,x5,x5 (held one extra cycle in ID)
    drv(1, 1, 0, 1, 0, 5, 1, 1, 0, 0);
    drv(1, 5, 5, 1, 1, 6, 1, 0, 0, 0);
    chk("t3_stall_if", stall_if, 1);
    chk("t3_flush_ex", flush_ex, 1);
    chk("t3_cnt_before", lu_cnt, 0);
    drv(1, 5, 5, 1, 1, 6, 1, 0, 0, 0);
    chk("t3_cnt_after", lu_cnt, 1);
    chk("t3_no_restall", stall_if, 0);
    nop(1);
    chk("t3_fwd_a", fwd_a, 2);
    chk("t3_fwd_b", fwd_b, 2);
    nop(3);
    // Load into x0 creates no hazard
    drv(1, 1, 0, 1, 0, 0, 1, 1, 0, 0);
    drv(1, 0, 0, 1, 1, 6, 1, 0, 0, 0);
    chk("t3_x0_stall", stall_if, 0);
    nop(3);
    chk("t3_x0_cnt", lu_cnt, 1);

    // Redirect overrides a live load-use hazard
    drv(1, 1, 0, 1, 0, 5, 1, 1, 0, 0);
    drv(1, 5, 5, 1, 1, 6, 1, 0, 1, 0);
    chk("t4_flush_id", flush_id, 1);
    chk("t4_flush_ex", flush_ex, 1);
    chk("t4_stall_if", stall_if, 0);
    nop(1);
    chk("t4_cnt", lu_cnt, 1);
    nop(3);

    // Busy freeze with a pending redirect: add x5 ; sub x6,x5,x3 then 3 busy cycles
    drv(1, 1, 2, 1, 1, 5, 1, 0, 0, 0);
    drv(1, 5, 3, 1, 1, 6, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drv(1, 1, 1, 1, 1, 9, 1, 0, 1, 1);
      chk("t5_freeze", freeze, 1);
      chk("t5_flush_id", flush_id, 0);
      chk("t5_fwd_a", fwd_a, 1);
    end
    drv(1, 1, 1, 1, 1, 9, 1, 0, 1, 0);
    chk("t5_rel_flush_id", flush_id, 1);
    chk("t5_rel_flush_ex", flush_ex, 1);
    chk("t5_rel_freeze", freeze, 0);
    nop(3);

    // Counter saturation at 2^CNT_W-1 = 3 (starts at 1)
    for (int i = 0; i < 3; i++) begin
      drv(1, 1, 0, 1, 0, 5, 1, 1, 0, 0);
      drv(1, 5, 5, 1, 1, 6, 1, 0, 0, 0);
      drv(1, 5, 5, 1, 1, 6, 1, 0, 0, 0);
      nop(2);
    end
    chk("t6_cnt_sat", lu_cnt, 3);

    // Asynchronous reset in the middle of a load-use stall
    drv(1, 1, 0, 1, 0, 5, 1, 1, 0, 0);
    drv(1, 5, 5, 1, 1, 6, 1, 0, 0, 0);
    chk("t6_pre_stall", stall_if, 1);
    #2 rstn = 1'b0;
    #1;
    chk("t6_rst_stall_if", stall_if, 0);
    chk("t6_rst_flush_ex", flush_ex, 0);
    chk("t6_rst_cnt", lu_cnt, 0);
    @(negedge clk); #1;
    rstn = 1'b1;
    nop(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
